// File: rtl/spi_updown_counter_dp.sv
// spi_updown_counter_dp: prescaled up/down modulo counter with load, wrap/saturate,
// terminal-count pulse and sticky wrap flag. Sits behind the SPI register decode.
module spi_updown_counter_dp #(
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned MAX_COUNT = 9999,
    parameter int unsigned TICK_DIV  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_o_runstop,
    input  logic             i_o_clear,
    input  logic             i_mode_down,
    input  logic             i_wrap_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] counter,
    output logic             o_tick,
    output logic             o_tc,
    output logic             o_wrapped
);

    // Prescaler needs at least one bit even when every clock is a tick.
    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_V  = '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;
    logic             tick_c;

    // Count tick: last prescaler phase while running.
    assign tick_c = i_o_runstop && (ps_q == PS_LAST);

    // Next-state: clear > load > tick > prescaler advance > hold.
    always_comb begin
        cnt_d     = cnt_q;
        ps_d      = ps_q;
        tick_d    = 1'b0;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;

        if (i_o_clear) begin
            cnt_d     = ZERO_V;
            ps_d      = '0;
            wrapped_d = 1'b0;
        end else if (i_load) begin
            cnt_d = (i_load_value > MAX_V) ? MAX_V : i_load_value;
            ps_d  = '0;
        end else if (tick_c) begin
            ps_d   = '0;
            tick_d = 1'b1;
            if (!i_mode_down) begin
                if (cnt_q > MAX_V) begin
                    cnt_d = ZERO_V;
                end else if (cnt_q == MAX_V) begin
                    tc_d = 1'b1;
                    if (i_wrap_en) begin
                        cnt_d     = ZERO_V;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q > MAX_V) begin
                    cnt_d = MAX_V;
                end else if (cnt_q == ZERO_V) begin
                    tc_d = 1'b1;
                    if (i_wrap_en) begin
                        cnt_d     = MAX_V;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end else if (i_o_runstop) begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= ZERO_V;
            ps_q      <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ps_q      <= ps_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign counter   = cnt_q;
    assign o_tick    = tick_q;
    assign o_tc      = tc_q;
    assign o_wrapped = wrapped_q;

endmodule

// File: doc/spi_updown_counter_dp.md
Name: spi_updown_counter_dp

Overview:
Parametrised successor to the SPI-controlled 14-bit up-counter datapath. It adds:
- an internal prescaler, so counting advances on a divided tick rather than every clock;
- up/down direction;
- a programmable modulo limit, with wrap or saturate at the limit;
- synchronous load;
- a terminal-count pulse and a sticky wrap flag.

It sits behind the SPI slave register decode, which drives the run/stop, clear, mode and load controls. Its count feeds the FND/display path.

Parameters:
WIDTH, 14, counter width in bits.
MAX_COUNT, 9999, highest count value; legal range 1 to 2**WIDTH-1.
TICK_DIV, 100000, clk cycles per count tick; must be ≥ 1 (1 = tick every cycle).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous active-high reset.
i_o_runstop  input  1  1 = run, 0 = stop (count and prescaler frozen).
i_o_clear  input  1  synchronous clear of count, prescaler and flags.
i_mode_down  input  1  0 = count up, 1 = count down.
i_wrap_en  input  1  1 = wrap at boundary, 0 = saturate (hold) at boundary.
i_load  input  1  synchronous load strobe.
i_load_value  input  WIDTH  value loaded on i_load.
counter  output  WIDTH  current count.
o_tick  output  1  registered copy of the internal count tick (1-cycle pulse).
o_tc  output  1  registered 1-cycle terminal-count pulse.
o_wrapped  output  1  sticky; set on any wrap event.

Behaviour:
- Clock, reset, and reset values:
  - Single clock domain: clk. Reset is asynchronous and active-high.
  - On reset, all of these go to 0: counter, prescaler, o_tick, o_tc, o_wrapped.
- Update priority at each rising edge: reset > i_o_clear > i_load > tick count > hold.
- Prescaler:
  - Internal counter of width $clog2(TICK_DIV), minimum 1 bit.
  - When i_o_runstop=1, it increments each clk and returns to 0 after reaching TICK_DIV-1.
  - Internal tick = i_o_runstop && (prescaler == TICK_DIV-1), evaluated combinationally.
  - When i_o_runstop=0, the prescaler holds its value. Resume continues from the same phase; no partial tick is lost.
- Clear (i_o_clear=1):
  - counter=0, prescaler=0, o_wrapped=0, o_tc=0, o_tick=0 on the next edge.
  - Clear overrides load and tick in the same cycle.
- Load (i_load=1, no clear):
  - counter = min(i_load_value, MAX_COUNT).
  - prescaler is reset to 0; o_tc=0.
  - Load wins over a coincident tick; that tick is dropped.
  - Load works whether running or stopped.
- Tick, up mode:
  - If counter < MAX_COUNT: counter+1.
  - If counter == MAX_COUNT: o_tc=1; counter=0 if i_wrap_en, else hold MAX_COUNT.
  - o_wrapped is set only when the counter actually wraps.
- Tick, down mode:
  - If counter > 0: counter-1.
  - If counter == 0: o_tc=1; counter=MAX_COUNT if i_wrap_en, else hold 0.
  - o_wrapped is set on wrap.
- Out-of-range counter: if counter is ever > MAX_COUNT (not reachable by design), an up tick forces it to 0 and a down tick to MAX_COUNT.
- o_tc and o_tick:
  - o_tc is high for exactly one cycle, registered on the boundary tick edge. It coincides with counter showing the wrap/hold value.
  - In saturate mode, o_tc re-pulses on every further boundary tick.
  - o_tick is high for the one cycle following each accepted internal tick.
- Control-change timing:
  - i_mode_down and i_wrap_en are sampled only at tick edges. A change mid-period takes effect at the next tick.
- Width rules:
  - Arithmetic is WIDTH bits, with no modular overflow beyond MAX_COUNT.
  - i_load_value is compared unsigned.
- Stop (i_o_runstop=0): counter, prescaler and o_wrapped hold; o_tc and o_tick are 0.

Test Plan:
1. TICK_DIV=4, MAX_COUNT=9, up, wrap_en=1, run 40 clks from reset → counter steps every 4 clks through 1..9. On the 10th tick it goes to 0 with o_tc=1 for 1 clk and o_wrapped=1.
2. Same configuration, wrap_en=0, run 60 clks → counter holds 9. o_tc pulses on ticks 10–15. o_wrapped stays 0.
3. Down mode, load 3, run → 2, 1, 0, then 9 with o_tc and o_wrapped set. Then wrap_en=0 from 0 → holds 0 with o_tc pulsing.
4. Run 2 clks into a period (prescaler=2), stop for 20 clks, resume → counter unchanged while stopped; next tick arrives 2 clks after resume.
5. Assert i_load (value 15, MAX=9) on the same cycle as a tick → counter=9, prescaler=0, no o_tc. Then assert clear and load together → counter=0 and o_wrapped=0.
6. Assert reset asynchronously mid-period while counter=7 → all outputs 0 immediately, without a clock edge. After release, counting restarts from 0 with a full TICK_DIV period.
